mem_responder: RTL and testbench

Memory-side responder for the CPU's memory strobe interface. It accepts one access at a time from the sequence controller's MEM_En/MEM_Wr strobes, inserts a parameterised number of wait states, then completes the access against an internal word array. It signals completion with a one-cycle Ready pulse. It sits between the address mux (PC / zero-extended IR field) plus register-file data path on one side and storage on the other, and replaces the zero-wait-state memory model.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Strobe bus between the sequence controller (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 9
);
    logic                 MEM_En;
    logic                 MEM_Wr;
    logic [AddrWidth-1:0] Addr;
    logic [DataWidth-1:0] DIn;
    logic [DataWidth-1:0] DOut;
    logic                 Ready;
    logic                 Busy;
    logic                 Error;

    modport master (
        output MEM_En, MEM_Wr, Addr, DIn,
        input  DOut, Ready, Busy, Error
    );

    modport slave (
        input  MEM_En, MEM_Wr, Addr, DIn,
        output DOut, Ready, Busy, Error
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one access per MEM_En strobe, WaitStates wait cycles,
// then a one-cycle Ready (with Error for out-of-range addresses).
//
// state  | meaning
// S_Idle | waiting for MEM_En low; accepts and latches the access
// S_Wait | counting down wait states; bus inputs ignored
// S_Ack  | Ready high for this cycle; access has completed
// S_Hold | strobe still held low after completion; wait for release
module mem_responder #(
    parameter int DataWidth  = 16,
    parameter int AddrWidth  = 9,
    parameter int MemWords   = 384,
    parameter int WaitStates = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_Idle = 2'b00,
        S_Wait = 2'b01,
        S_Ack  = 2'b10,
        S_Hold = 2'b11
    } state_t;

    localparam logic [3:0]         WaitLoad  = WaitStates[3:0];
    localparam logic [AddrWidth:0] AddrLimit = MemWords[AddrWidth:0];

    state_t               state;
    logic [3:0]           wait_cnt;
    logic [AddrWidth-1:0] addr_q;
    logic                 wr_q;
    logic [DataWidth-1:0] data_q;
    logic [DataWidth-1:0] dout_q;
    logic                 ready_q;
    logic                 error_q;

    logic [DataWidth-1:0] mem [MemWords];

    logic                 complete;
    logic [AddrWidth-1:0] acc_addr;
    logic                 acc_wr;
    logic [DataWidth-1:0] acc_data;
    logic                 acc_in_range;

    // Select the access that completes on this edge; with zero wait states the
    // accepting edge is also the completing edge, so the live bus is used.
    always_comb begin
        complete = 1'b0;
        acc_addr = addr_q;
        acc_wr   = wr_q;
        acc_data = data_q;
        if (state == S_Idle && !bus.MEM_En && WaitStates == 0) begin
            complete = 1'b1;
            acc_addr = bus.Addr;
            acc_wr   = bus.MEM_Wr;
            acc_data = bus.DIn;
        end else if (state == S_Wait && wait_cnt == 4'd1) begin
            complete = 1'b1;
        end
    end

    assign acc_in_range = ({1'b0, acc_addr} < AddrLimit);

    // Array write on the completing edge; held off while Reset is asserted so an
    // access cannot land during reset.
    always_ff @(posedge Clk) begin
        if (!Reset && complete && !acc_wr && acc_in_range) begin
            mem[acc_addr] <= acc_data;
        end
    end

    // Sequencing FSM with registered Ready/Error/DOut.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_Idle;
            wait_cnt <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                S_Idle: begin
                    if (!bus.MEM_En) begin
                        addr_q   <= bus.Addr;
                        wr_q     <= bus.MEM_Wr;
                        data_q   <= bus.DIn;
                        wait_cnt <= WaitLoad;
                        state    <= (WaitStates > 0) ? S_Wait : S_Ack;
                    end
                end
                S_Wait: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_Ack;
                    end
                end
                S_Ack: begin
                    state <= bus.MEM_En ? S_Idle : S_Hold;
                end
                S_Hold: begin
                    if (bus.MEM_En) begin
                        state <= S_Idle;
                    end
                end
                default: state <= S_Idle;
            endcase
            if (complete) begin
                ready_q <= 1'b1;
                error_q <= !acc_in_range;
                if (acc_wr) begin
                    dout_q <= acc_in_range ? mem[acc_addr] : '0;
                end
            end
        end
    end

    assign bus.DOut  = dout_q;
    assign bus.Ready = ready_q;
    assign bus.Error = error_q;
    assign bus.Busy  = (state != S_Idle);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders with WaitStates = 0, 1 and 3 on one clock.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  en;
    logic [2:0]  wr;
    logic [8:0]  addr [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic [2:0]  rdy;
    logic [2:0]  bsy;
    logic [2:0]  err;

    int tests  = 0;
    int failed = 0;
    int ws_of [3] = '{0, 1, 3};

    always #5 Clk = ~Clk;

    mem_responder_if #(.DataWidth(16), .AddrWidth(9)) bus_w0 ();
    mem_responder_if #(.DataWidth(16), .AddrWidth(9)) bus_w1 ();
    mem_responder_if #(.DataWidth(16), .AddrWidth(9)) bus_w3 ();

    assign bus_w0.MEM_En = en[0];
    assign bus_w0.MEM_Wr = wr[0];
    assign bus_w0.Addr   = addr[0];
    assign bus_w0.DIn    = din[0];
    assign dout[0] = bus_w0.DOut;
    assign rdy[0]  = bus_w0.Ready;
    assign bsy[0]  = bus_w0.Busy;
    assign err[0]  = bus_w0.Error;

    assign bus_w1.MEM_En = en[1];
    assign bus_w1.MEM_Wr = wr[1];
    assign bus_w1.Addr   = addr[1];
    assign bus_w1.DIn    = din[1];
    assign dout[1] = bus_w1.DOut;
    assign rdy[1]  = bus_w1.Ready;
    assign bsy[1]  = bus_w1.Busy;
    assign err[1]  = bus_w1.Error;

    assign bus_w3.MEM_En = en[2];
    assign bus_w3.MEM_Wr = wr[2];
    assign bus_w3.Addr   = addr[2];
    assign bus_w3.DIn    = din[2];
    assign dout[2] = bus_w3.DOut;
    assign rdy[2]  = bus_w3.Ready;
    assign bsy[2]  = bus_w3.Busy;
    assign err[2]  = bus_w3.Error;

    mem_responder #(.DataWidth(16), .AddrWidth(9), .MemWords(384), .WaitStates(0)) dut_w0 (
        .Clk(Clk), .Reset(rst[0]), .bus(bus_w0.slave));
    mem_responder #(.DataWidth(16), .AddrWidth(9), .MemWords(384), .WaitStates(1)) dut_w1 (
        .Clk(Clk), .Reset(rst[1]), .bus(bus_w1.slave));
    mem_responder #(.DataWidth(16), .AddrWidth(9), .MemWords(384), .WaitStates(3)) dut_w3 (
        .Clk(Clk), .Reset(rst[2]), .bus(bus_w3.slave));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample at the falling edge.
    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Single-cycle strobe; Ready expected WaitStates samples after the accept sample.
    task automatic do_access(input int i, input string tag, input logic w, input logic [8:0] a,
                             input logic [15:0] d, input logic exp_err, input logic [15:0] exp_dout);
        en[i] = 1'b0; wr[i] = w; addr[i] = a; din[i] = d;
        cyc();
        en[i] = 1'b1;
        for (int k = 0; k < ws_of[i]; k++) begin
            check({tag, "_wait_ready"}, rdy[i], 1'b0);
            check({tag, "_wait_busy"}, bsy[i], 1'b1);
            cyc();
        end
        check({tag, "_ready"}, rdy[i], 1'b1);
        check({tag, "_error"}, err[i], exp_err);
        check({tag, "_dout"}, dout[i], exp_dout);
        cyc();
        check({tag, "_ready_drop"}, rdy[i], 1'b0);
        check({tag, "_idle_busy"}, bsy[i], 1'b0);
        check({tag, "_error_drop"}, err[i], 1'b0);
    endtask

    initial begin
        int pulses;
        logic busy_all;
        logic rdy_seen;

        rst = 3'b111; en = 3'b111; wr = 3'b111;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; din[i] = '0; end
        @(negedge Clk);
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_dout", dout[i], 16'h0000);
            check("rst_ready", rdy[i], 1'b0);
            check("rst_busy", bsy[i], 1'b0);
            check("rst_error", err[i], 1'b0);
        end
        rst = 3'b000;

        // WaitStates = 1: basic write/read
        do_access(1, "w1_wr5", 1'b0, 9'h005, 16'hBEEF, 1'b0, 16'h0000);
        do_access(1, "w1_wr0", 1'b0, 9'h000, 16'h0F0F, 1'b0, 16'h0000);
        do_access(1, "w1_rd5", 1'b1, 9'h005, 16'h0000, 1'b0, 16'hBEEF);

        // Asynchronous reset mid-cycle while Ready is high
        en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 9'h005;
        cyc();
        en[1] = 1'b1;
        cyc();
        check("pre_rst_ready", rdy[1], 1'b1);
        #2 rst[1] = 1'b1;
        #1;
        check("async_rst_dout", dout[1], 16'h0000);
        check("async_rst_ready", rdy[1], 1'b0);
        check("async_rst_busy", bsy[1], 1'b0);
        check("async_rst_error", err[1], 1'b0);
        @(negedge Clk);
        rst[1] = 1'b0;

        // Array survives reset; out-of-range write/read; address 0 unaffected
        do_access(1, "w1_rd5_after_rst", 1'b1, 9'h005, 16'h0000, 1'b0, 16'hBEEF);
        do_access(1, "oor_wr", 1'b0, 9'h1A0, 16'h1234, 1'b1, 16'hBEEF);
        do_access(1, "oor_rd", 1'b1, 9'h1A0, 16'h0000, 1'b1, 16'h0000);
        do_access(1, "rd0_after_oor", 1'b1, 9'h000, 16'h0000, 1'b0, 16'h0F0F);

        // Held strobe: 8 low cycles yield one access then park in S_Hold
        en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 9'h005;
        pulses = 0; busy_all = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (rdy[1] === 1'b1) pulses++;
            if (bsy[1] !== 1'b1) busy_all = 1'b0;
        end
        check("hold_ready_pulses", 16'(pulses), 16'd1);
        check("hold_busy_all", busy_all, 1'b1);
        check("hold_state", dut_w1.state, 2'b11);
        check("hold_dout", dout[1], 16'hBEEF);
        en[1] = 1'b1;
        cyc();
        check("hold_release_busy", bsy[1], 1'b0);
        check("hold_release_ready", rdy[1], 1'b0);

        // WaitStates = 3: reset during S_Wait discards the pending write
        do_access(2, "w3_wr7", 1'b0, 9'h007, 16'h5555, 1'b0, 16'h0000);
        en[2] = 1'b0; wr[2] = 1'b0; addr[2] = 9'h007; din[2] = 16'hAAAA;
        cyc();
        en[2] = 1'b1;
        cyc();
        check("w3_abort_busy_before", bsy[2], 1'b1);
        #2 rst[2] = 1'b1;
        #1;
        check("w3_abort_busy", bsy[2], 1'b0);
        check("w3_abort_ready", rdy[2], 1'b0);
        @(negedge Clk);
        rst[2] = 1'b0;
        rdy_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (rdy[2] !== 1'b0) rdy_seen = 1'b1;
        end
        check("w3_abort_no_ready", rdy_seen, 1'b0);
        do_access(2, "w3_rd7", 1'b1, 9'h007, 16'h0000, 1'b0, 16'h5555);

        // WaitStates = 0: Ready on the accept edge, strobes while busy ignored
        do_access(0, "w0_wr2", 1'b0, 9'h002, 16'h3C3C, 1'b0, 16'h0000);
        do_access(0, "w0_wr3", 1'b0, 9'h003, 16'h2222, 1'b0, 16'h0000);
        en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 9'h002;
        cyc();
        check("w0_rd2_ready", rdy[0], 1'b1);
        check("w0_rd2_dout", dout[0], 16'h3C3C);
        check("w0_rd2_busy", bsy[0], 1'b1);
        wr[0] = 1'b0; addr[0] = 9'h003; din[0] = 16'h1111;
        cyc();
        check("w0_busy_strobe_ready", rdy[0], 1'b0);
        check("w0_busy_strobe_busy", bsy[0], 1'b1);
        en[0] = 1'b1;
        cyc();
        check("w0_busy_strobe_idle", bsy[0], 1'b0);
        check("w0_busy_strobe_noready", rdy[0], 1'b0);
        do_access(0, "w0_rd3_kept", 1'b1, 9'h003, 16'h0000, 1'b0, 16'h2222);
        do_access(0, "w0_b2b_rd2", 1'b1, 9'h002, 16'h0000, 1'b0, 16'h3C3C);
        do_access(0, "w0_b2b_wr3", 1'b0, 9'h003, 16'h4444, 1'b0, 16'h3C3C);
        do_access(0, "w0_rd3_new", 1'b1, 9'h003, 16'h0000, 1'b0, 16'h4444);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
